mux3_rr_sched: RTL and testbench

- Round-robin scheduler that shares one W-bit output channel among three valid/ready requesters.
- Produces the 2-bit select code for the team's 3:1 zero-default channel mux: 00 = zero/idle, 01 = ch_0, 10 = ch_1, 11 = ch_2.
- Holds a registered output stage with valid/ready handshake.
- Supports bounded bursts per grant so no requester can starve the others.

---
 rtl/mux3_rr_sched.sv | 121 ++++++++++++
 tb/tb_mux3_rr_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux3_rr_sched.sv
// Round-robin scheduler sharing one registered W-bit output among three
// valid/ready requesters, with bounded bursts per grant.
module mux3_rr_sched #(
  parameter int W         = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ch_0_valid,
  input  logic [W-1:0] ch_0_data,
  output logic         ch_0_ready,
  input  logic         ch_1_valid,
  input  logic [W-1:0] ch_1_data,
  output logic         ch_1_ready,
  input  logic         ch_2_valid,
  input  logic [W-1:0] ch_2_data,
  output logic         ch_2_ready,
  output logic [1:0]   select,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nx;
  logic [1:0]          g, g_nx, last_grant, last_nx, select_nx, rr_base, win;
  logic [CW-1:0]       burst_cnt, burst_nx;
  logic [2:0]          vld, rdy;
  logic [2:0][W-1:0]   dat;
  logic                any, gv, can_load, gnt_rdy, xfer, rel;
  logic [W-1:0]        gdat;

  assign vld = {ch_2_valid, ch_1_valid, ch_0_valid};
  assign dat = {ch_2_data, ch_1_data, ch_0_data};

  assign can_load = !out_valid || out_ready;
  assign gnt_rdy  = (state == GRANT) && can_load;
  assign gv       = vld[g];
  assign gdat     = dat[g];
  assign xfer     = gnt_rdy && gv;
  assign rel      = (state == GRANT) &&
                    (!gv || (xfer && burst_cnt == CW'(MAX_BURST - 1)));

  always_comb begin
    rdy = '0;
    for (int i = 0; i < 3; i++) rdy[i] = gnt_rdy && (g == 2'(i));
  end
  assign ch_0_ready = rdy[0];
  assign ch_1_ready = rdy[1];
  assign ch_2_ready = rdy[2];

  // Search g+1, g+2, g+3 (mod 3); walking downward lets the nearest win.
  assign rr_base = (state == GRANT) ? g : last_grant;
  always_comb begin
    any = 1'b0;
    win = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      if (vld[(int'(rr_base) + i) % 3]) begin
        any = 1'b1;
        win = 2'((int'(rr_base) + i) % 3);
      end
    end
  end

  always_comb begin
    state_nx = state;
    g_nx     = g;
    last_nx  = last_grant;
    burst_nx = burst_cnt;
    case (state)
      IDLE: begin
        if (any) begin
          state_nx = GRANT;
          g_nx     = win;
          burst_nx = '0;
        end
      end
      GRANT: begin
        if (xfer) burst_nx = burst_cnt + CW'(1);
        if (rel) begin
          last_nx  = g;
          burst_nx = '0;
          if (any) g_nx = win;
          else     state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    select_nx = (state_nx == GRANT) ? 2'(g_nx + 2'd1) : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      g          <= 2'd0;
      last_grant <= 2'd2;
      burst_cnt  <= '0;
      select     <= 2'd0;
    end else begin
      state      <= state_nx;
      g          <= g_nx;
      last_grant <= last_nx;
      burst_cnt  <= burst_nx;
      select     <= select_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gdat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux3_rr_sched.sv
// Directed bench for mux3_rr_sched: scripted requesters, per-cycle sample log,
// and hand-computed grant order / data streams.
module tb_mux3_rr_sched;
  localparam int W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        vin;
  logic [2:0][W-1:0] din;
  logic [2:0]        rdy;
  logic [1:0]        select;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready = 1'b1;

  always #5 clk = ~clk;

  mux3_rr_sched #(.W(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .ch_0_valid(vin[0]), .ch_0_data(din[0]), .ch_0_ready(rdy[0]),
    .ch_1_valid(vin[1]), .ch_1_data(din[1]), .ch_1_ready(rdy[1]),
    .ch_2_valid(vin[2]), .ch_2_data(din[2]), .ch_2_ready(rdy[2]),
    .select(select), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  int           cnt[3], sent[3];
  logic [W-1:0] base[3];
  int           xch[$], xcyc[$];
  logic [1:0]   xsel[$];
  logic [W-1:0] rx[$];
  logic [1:0]   s_sel[$];
  logic [2:0]   s_rdy[$];
  logic         s_ov[$];
  logic [W-1:0] s_od[$];
  int           cyc, tests, fails;

  task automatic clear_log();
    xch.delete(); xcyc.delete(); xsel.delete(); rx.delete();
    s_sel.delete(); s_rdy.delete(); s_ov.delete(); s_od.delete();
    cyc = 0;
  endtask

  task automatic idle_sources();
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; sent[i] = 0; base[i] = '0; end
  endtask

  // One clock: requesters present, sample mid-cycle, advance after the edge.
  task automatic cycle();
    logic [2:0] took;
    for (int i = 0; i < 3; i++) begin
      vin[i] = cnt[i] > 0;
      din[i] = base[i] + W'(sent[i]);
    end
    @(negedge clk);
    took = '0;
    for (int i = 0; i < 3; i++)
      if (vin[i] && rdy[i]) begin
        took[i] = 1'b1;
        xch.push_back(i); xcyc.push_back(cyc); xsel.push_back(select);
      end
    if (out_valid && out_ready) rx.push_back(out_data);
    s_sel.push_back(select); s_rdy.push_back(rdy);
    s_ov.push_back(out_valid); s_od.push_back(out_data);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) if (took[i]) begin sent[i]++; cnt[i]--; end
    cyc++;
  endtask

  task automatic do_reset();
    idle_sources();
    out_ready = 1'b1;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) cycle();
    for (int c = 0; c < 10; c++) begin
      tests++;
      if ({s_sel[c], s_ov[c], s_od[c], s_rdy[c]} !== '0) begin
        fails++;
        $display("FAIL reset_idle c%0d: sel=%b ov=%b od=%h rdy=%b, need all 0",
                 c, s_sel[c], s_ov[c], s_od[c], s_rdy[c]);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    base[1] = 32'hA0; cnt[1] = 6;
    for (int c = 0; c < 10; c++) cycle();
    tests++; if (s_sel[0] !== 2'b00 || s_rdy[0] !== 3'b000) begin fails++;
      $display("FAIL single_arb: sel=%b rdy=%b, need 00/000", s_sel[0], s_rdy[0]); end
    tests++; if (s_sel[1] !== 2'b10) begin fails++;
      $display("FAIL single_sel: sel=%b, need 10", s_sel[1]); end
    tests++; if (xch.size() != 6) begin fails++;
      $display("FAIL single_count: %0d transfers, need 6", xch.size()); end
    for (int k = 0; k < xch.size(); k++) begin
      tests++;
      if (xch[k] != 1 || xsel[k] !== 2'b10 || xcyc[k] != k + 1) begin fails++;
        $display("FAIL single_xfer%0d: ch=%0d sel=%b cyc=%0d, need 1/10/%0d",
                 k, xch[k], xsel[k], xcyc[k], k + 1); end
    end
    tests++; if (rx.size() != 6) begin fails++;
      $display("FAIL single_rx_count: %0d words, need 6", rx.size()); end
    for (int k = 0; k < rx.size(); k++) begin
      tests++;
      if (rx[k] !== 32'hA0 + W'(k)) begin fails++;
        $display("FAIL single_rx%0d: got %h, need %h", k, rx[k], 32'hA0 + W'(k)); end
    end
    tests++; if (s_sel[8] !== 2'b00 || s_ov[8] !== 1'b0) begin fails++;
      $display("FAIL single_idle: sel=%b ov=%b, need 00/0", s_sel[8], s_ov[8]); end
  endtask

  task automatic test_round_robin();
    int exp_ch, seen[3];
    do_reset();
    base[0] = 32'h100; base[1] = 32'h200; base[2] = 32'h300;
    cnt[0] = 8; cnt[1] = 8; cnt[2] = 8;
    for (int c = 0; c < 30; c++) cycle();
    tests++; if (xch.size() != 24) begin fails++;
      $display("FAIL rr_count: %0d transfers, need 24", xch.size()); end
    for (int k = 0; k < xch.size(); k++) begin
      exp_ch = (k / 4) % 3;
      tests++;
      if (xch[k] != exp_ch || xsel[k] !== 2'(exp_ch + 1) || xcyc[k] != k + 1) begin fails++;
        $display("FAIL rr_xfer%0d: ch=%0d sel=%b cyc=%0d, need %0d/%0d/%0d",
                 k, xch[k], xsel[k], xcyc[k], exp_ch, exp_ch + 1, k + 1); end
    end
    seen = '{0, 0, 0};
    tests++; if (rx.size() != 24) begin fails++;
      $display("FAIL rr_rx_count: %0d words, need 24", rx.size()); end
    for (int k = 0; k < rx.size(); k++) begin
      exp_ch = (k / 4) % 3;
      tests++;
      if (rx[k] !== W'(32'h100 * (exp_ch + 1) + seen[exp_ch])) begin fails++;
        $display("FAIL rr_rx%0d: got %h, need %h", k, rx[k],
                 W'(32'h100 * (exp_ch + 1) + seen[exp_ch])); end
      seen[exp_ch]++;
    end
  endtask

  task automatic test_backpressure();
    int           ech[8], ecy[8];
    logic [W-1:0] ew[8];
    ech = '{2, 2, 2, 2, 0, 0, 2, 2};
    ecy = '{1, 7, 8, 9, 10, 11, 13, 14};
    ew  = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h100, 32'h101, 32'h304, 32'h305};
    do_reset();
    base[2] = 32'h300; cnt[2] = 6; base[0] = 32'h100;
    cycle(); cycle();
    out_ready = 1'b0; cnt[0] = 2;
    for (int c = 0; c < 5; c++) cycle();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) cycle();
    for (int c = 2; c <= 6; c++) begin
      tests++;
      if (s_rdy[c] !== 3'b000 || s_ov[c] !== 1'b1 || s_od[c] !== 32'h300 || s_sel[c] !== 2'b11) begin
        fails++;
        $display("FAIL bp_stall c%0d: rdy=%b ov=%b od=%h sel=%b, need 000/1/300/11",
                 c, s_rdy[c], s_ov[c], s_od[c], s_sel[c]); end
    end
    tests++; if (xch.size() != 8) begin fails++;
      $display("FAIL bp_count: %0d transfers, need 8", xch.size()); end
    for (int k = 0; k < xch.size() && k < 8; k++) begin
      tests++;
      if (xch[k] != ech[k] || xcyc[k] != ecy[k]) begin fails++;
        $display("FAIL bp_xfer%0d: ch=%0d cyc=%0d, need %0d/%0d",
                 k, xch[k], xcyc[k], ech[k], ecy[k]); end
    end
    for (int k = 0; k < rx.size() && k < 8; k++) begin
      tests++;
      if (rx[k] !== ew[k]) begin fails++;
        $display("FAIL bp_rx%0d: got %h, need %h", k, rx[k], ew[k]); end
    end
  endtask

  task automatic test_early_release();
    int           ech[6], ecy[6];
    logic [W-1:0] ew[6];
    ech = '{0, 0, 2, 2, 2, 2};
    ecy = '{1, 2, 4, 5, 6, 7};
    ew  = '{32'h100, 32'h101, 32'h300, 32'h301, 32'h302, 32'h303};
    do_reset();
    base[0] = 32'h100; cnt[0] = 2; base[2] = 32'h300; cnt[2] = 4;
    for (int c = 0; c < 10; c++) cycle();
    tests++; if (s_sel[3] !== 2'b01 || s_sel[4] !== 2'b11) begin fails++;
      $display("FAIL early_sel: c3=%b c4=%b, need 01/11", s_sel[3], s_sel[4]); end
    tests++; if (xch.size() != 6 || rx.size() != 6) begin fails++;
      $display("FAIL early_count: %0d transfers %0d words, need 6/6", xch.size(), rx.size()); end
    for (int k = 0; k < xch.size() && k < 6; k++) begin
      tests++;
      if (xch[k] != ech[k] || xcyc[k] != ecy[k]) begin fails++;
        $display("FAIL early_xfer%0d: ch=%0d cyc=%0d, need %0d/%0d",
                 k, xch[k], xcyc[k], ech[k], ecy[k]); end
    end
    for (int k = 0; k < rx.size() && k < 6; k++) begin
      tests++;
      if (rx[k] !== ew[k]) begin fails++;
        $display("FAIL early_rx%0d: got %h, need %h", k, rx[k], ew[k]); end
    end
  endtask

  task automatic test_midburst_reset();
    do_reset();
    base[1] = 32'h200; cnt[1] = 8;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    base[0] = 32'h100; cnt[0] = 2;
    for (int c = 0; c < 5; c++) cycle();
    tests++; if (xch.size() < 3 || xcyc[2] != 3 || xch[2] != 1) begin fails++;
      $display("FAIL mrst_setup: %0d transfers, need ch1 third transfer at c3", xch.size()); end
    tests++; if (s_sel[4] !== 2'b00 || s_ov[4] !== 1'b0 || s_od[4] !== '0 || s_rdy[4] !== 3'b000) begin
      fails++;
      $display("FAIL mrst_clear: sel=%b ov=%b od=%h rdy=%b, need 00/0/0/000",
               s_sel[4], s_ov[4], s_od[4], s_rdy[4]); end
    tests++; if (s_sel[5] !== 2'b01 || s_rdy[5] !== 3'b001) begin fails++;
      $display("FAIL mrst_first: sel=%b rdy=%b, need 01/001", s_sel[5], s_rdy[5]); end
    tests++; if (xch.size() < 4 || xch[3] != 0 || xcyc[3] != 5) begin fails++;
      $display("FAIL mrst_xfer: size=%0d, need ch0 transfer at c5", xch.size()); end
  endtask

  initial begin
    tests = 0; fails = 0;
    vin = '0; din = '0;
    idle_sources();
    clear_log();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_midburst_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
